// File: rtl/operand_assembler_pkg.sv
// operand_assembler_pkg: shared FSM state type and command tag value
package operand_assembler_pkg;
  typedef enum logic [0:0] {COLLECT = 1'b0, ISSUE = 1'b1} state_t;
  localparam int TAG_CMD = 0;
endpackage

// File: rtl/operand_shreg.sv
// operand_shreg: one operand register filled MSB chunk first, with own chunk counter and complete flag
module operand_shreg #(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [CHUNK_W-1:0] chunk,
  input  logic               clr_flags,
  output logic [DATA_W-1:0]  data,
  output logic               complete
);
  localparam int CHUNKS = DATA_W / CHUNK_W;
  localparam int CNT_W  = CHUNKS > 1 ? $clog2(CHUNKS) : 1;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] slot;
  logic             last;
  // a beat to a complete operand restarts it at the MSB slice
  assign slot = complete ? '0 : cnt;
  assign last = (CHUNKS == 1) || (slot == CNT_W'(CHUNKS - 1));
  // slice write, counter advance/wrap, completion tracking
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      data     <= '0;
      cnt      <= '0;
      complete <= 1'b0;
    end else if (clr_flags) begin
      cnt      <= '0;
      complete <= 1'b0;
    end else if (wr_en) begin
      data[DATA_W-1-int'(slot)*CHUNK_W -: CHUNK_W] <= chunk;
      cnt      <= last ? '0 : slot + 1'b1;
      complete <= last;
    end
  end
endmodule

// File: rtl/operand_assembler.sv
// operand_assembler: assembles NUM_OPS chunked operands plus opcode behind valid/ready; IN_PARITY_EN adds even-parity beat checking
module operand_assembler
  import operand_assembler_pkg::*;
#(
  parameter int DATA_W  = 16,
  parameter int CHUNK_W = 8,
  parameter int NUM_OPS = 2,
  parameter int OP_W    = 4,
  localparam int TAG_W  = $clog2(NUM_OPS + 1)
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [TAG_W-1:0]          in_tag,
  input  logic [CHUNK_W-1:0]        in_data,
`ifdef IN_PARITY_EN
  input  logic                      in_par,
`endif
  output logic [NUM_OPS*DATA_W-1:0] ops,
  output logic [OP_W-1:0]           op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      err
);
  state_t               state;
  logic [NUM_OPS-1:0]   complete;
  logic [NUM_OPS-1:0]   wr_en;
  logic                 accept, par_ok, is_cmd, bad_tag, all_done, fire, err_d, done;
  assign in_ready  = state == COLLECT;
  assign out_valid = state == ISSUE;
  assign accept    = in_valid && in_ready;
`ifdef IN_PARITY_EN
  assign par_ok    = ~^{in_tag, in_data, in_par};
`else
  assign par_ok    = 1'b1;
`endif
  assign is_cmd    = in_tag == TAG_W'(TAG_CMD);
  assign bad_tag   = in_tag > TAG_W'(NUM_OPS);
  assign all_done  = &complete;
  assign fire      = accept && par_ok && is_cmd && all_done;
  assign err_d     = accept && (!par_ok || bad_tag || (is_cmd && !all_done));
  assign done      = out_valid && out_ready;
  for (genvar g = 0; g < NUM_OPS; g++) begin : g_op
    assign wr_en[g] = accept && par_ok && in_tag == TAG_W'(g + 1);
    operand_shreg #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W)) u_shreg (
      .clock     (clock),
      .reset_n   (reset_n),
      .wr_en     (wr_en[g]),
      .chunk     (in_data),
      .clr_flags (done),
      .data      (ops[g*DATA_W +: DATA_W]),
      .complete  (complete[g])
    );
  end
  // collect/issue sequencing, opcode latch and registered error pulse
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= COLLECT;
      op    <= '0;
      err   <= 1'b0;
    end else begin
      err <= err_d;
      if (fire) begin
        state <= ISSUE;
        op    <= in_data[OP_W-1:0];
      end else if (done) state <= COLLECT;
    end
  end
endmodule

// File: tb/tb_operand_assembler.sv
// tb_operand_assembler: table vectors, directed corner sequences and random stimulus against a reference model
module tb_operand_assembler;
  localparam int DATA_W  = 16;
  localparam int CHUNK_W = 8;
  localparam int NUM_OPS = 2;
  localparam int OP_W    = 4;
  localparam int TAG_W   = 2;
  localparam int CHUNKS  = DATA_W / CHUNK_W;
  logic clock = 0, reset_n = 1, in_valid = 0, out_ready = 0;
  logic in_ready, out_valid, err;
  logic [TAG_W-1:0] in_tag = '0;
  logic [CHUNK_W-1:0] in_data = '0;
  logic [NUM_OPS*DATA_W-1:0] ops;
  logic [OP_W-1:0] op;
`ifdef IN_PARITY_EN
  logic in_par = 0;
`endif
  int n_chk = 0, n_err = 0;
  logic [DATA_W-1:0] m_val[NUM_OPS];
  int m_n[NUM_OPS];
  logic m_issue, m_err;
  logic [OP_W-1:0] m_op;
  typedef struct {
    logic v; logic [TAG_W-1:0] tag; logic [CHUNK_W-1:0] d; logic ordy;
    logic ov, rdy, er; logic [OP_W-1:0] op; logic [31:0] ops;
  } vec_t;
  vec_t tbl[12];
  always #5 clock = ~clock;
  operand_assembler #(.DATA_W(DATA_W), .CHUNK_W(CHUNK_W), .NUM_OPS(NUM_OPS), .OP_W(OP_W)) dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_tag(in_tag), .in_data(in_data),
`ifdef IN_PARITY_EN
    .in_par(in_par),
`endif
    .ops(ops), .op(op), .out_valid(out_valid), .out_ready(out_ready), .err(err)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic logic [NUM_OPS*DATA_W-1:0] m_ops();
    logic [NUM_OPS*DATA_W-1:0] r;
    for (int i = 0; i < NUM_OPS; i++) r[i*DATA_W +: DATA_W] = m_val[i];
    return r;
  endfunction
  task automatic m_reset();
    for (int i = 0; i < NUM_OPS; i++) begin m_val[i] = '0; m_n[i] = 0; end
    m_issue = 0; m_err = 0; m_op = '0;
  endtask
  task automatic m_step(input logic v, input logic [TAG_W-1:0] tag, input logic [CHUNK_W-1:0] d,
                        input logic ordy, input logic bad_par);
    bit all;
    int k, sh;
    logic [DATA_W-1:0] mk;
    m_err = 0;
    if (m_issue) begin
      if (ordy) begin
        m_issue = 0;
        for (int i = 0; i < NUM_OPS; i++) m_n[i] = 0;
      end
    end else if (v) begin
      if (bad_par || tag > NUM_OPS) m_err = 1;
      else if (tag == 0) begin
        all = 1;
        for (int i = 0; i < NUM_OPS; i++) if (m_n[i] != CHUNKS) all = 0;
        if (all) begin m_op = d[OP_W-1:0]; m_issue = 1; end
        else m_err = 1;
      end else begin
        k = int'(tag) - 1;
        if (m_n[k] == CHUNKS) m_n[k] = 0;
        sh = DATA_W - (m_n[k] + 1) * CHUNK_W;
        mk = DATA_W'({CHUNK_W{1'b1}}) << sh;
        m_val[k] = (m_val[k] & ~mk) | (DATA_W'(d) << sh);
        m_n[k]++;
      end
    end
  endtask
  task automatic check_all();
    chk("out_valid", out_valid, m_issue);
    chk("in_ready", in_ready, !m_issue);
    chk("err", err, m_err);
    chk("op", op, m_op);
    chk("ops", ops, m_ops());
  endtask
  task automatic cyc(input logic v, input logic [TAG_W-1:0] tag, input logic [CHUNK_W-1:0] d,
                     input logic ordy, input logic bp);
    in_valid = v; in_tag = tag; in_data = d; out_ready = ordy;
`ifdef IN_PARITY_EN
    in_par = ^{tag, d} ^ bp;
`endif
    m_step(v, tag, d, ordy, bp);
    @(posedge clock);
    #1;
    in_valid = 0;
    check_all();
  endtask
  initial begin
    tbl[0]  = '{1'b1, 2'd1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h00001200};
    tbl[1]  = '{1'b1, 2'd1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'h00001234};
    tbl[2]  = '{1'b1, 2'd2, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'hAB001234};
    tbl[3]  = '{1'b1, 2'd2, 8'hCD, 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 32'hABCD1234};
    tbl[4]  = '{1'b1, 2'd0, 8'h05, 1'b1, 1'b1, 1'b0, 1'b0, 4'h5, 32'hABCD1234};
    tbl[5]  = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'hABCD1234};
    tbl[6]  = '{1'b1, 2'd1, 8'h12, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'hABCD1234};
    tbl[7]  = '{1'b1, 2'd2, 8'hAB, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'hABCD1234};
    tbl[8]  = '{1'b1, 2'd1, 8'h34, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'hABCD1234};
    tbl[9]  = '{1'b1, 2'd2, 8'hCD, 1'b1, 1'b0, 1'b1, 1'b0, 4'h5, 32'hABCD1234};
    tbl[10] = '{1'b1, 2'd0, 8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 4'h3, 32'hABCD1234};
    tbl[11] = '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 4'h3, 32'hABCD1234};
    m_reset();
    #1 reset_n = 0;
    #1;
    chk("rst_ops", ops, 0);
    chk("rst_op", op, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_err", err, 0);
    chk("rst_in_ready", in_ready, 1);
    @(negedge clock) reset_n = 1;
    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].v, tbl[i].tag, tbl[i].d, tbl[i].ordy, 1'b0);
      chk($sformatf("tbl%0d_ov", i), out_valid, tbl[i].ov);
      chk($sformatf("tbl%0d_rdy", i), in_ready, tbl[i].rdy);
      chk($sformatf("tbl%0d_err", i), err, tbl[i].er);
      chk($sformatf("tbl%0d_op", i), op, tbl[i].op);
      chk($sformatf("tbl%0d_ops", i), ops, tbl[i].ops);
    end
    cyc(1, 1, 8'h56, 1, 0);
    cyc(1, 1, 8'h78, 1, 0);
    cyc(1, 0, 8'h09, 1, 0);
    chk("inc_cmd_err", err, 1);
    chk("inc_cmd_op", op, 3);
    chk("inc_cmd_ov", out_valid, 0);
    cyc(0, 0, 8'h00, 1, 0);
    chk("inc_cmd_err_clr", err, 0);
    cyc(1, 2, 8'h9A, 1, 0);
    cyc(1, 2, 8'hBC, 1, 0);
    cyc(1, 0, 8'h09, 0, 0);
    chk("reissue_ov", out_valid, 1);
    chk("reissue_op", op, 9);
    chk("reissue_ops", ops, 32'h9ABC5678);
    for (int i = 0; i < 5; i++) begin
      cyc(1, 1, CHUNK_W'($urandom), 0, 0);
      chk("bp_rdy", in_ready, 0);
      chk("bp_ov", out_valid, 1);
      chk("bp_ops", ops, 32'h9ABC5678);
      chk("bp_op", op, 9);
    end
    cyc(0, 0, 8'h00, 1, 0);
    chk("bp_release_ov", out_valid, 0);
    cyc(1, 1, 8'hEE, 1, 0);
    chk("bp_next_beat", ops, 32'h9ABCEE78);
    cyc(1, 1, 8'hFF, 1, 0);
    cyc(1, 2, 8'h11, 1, 0);
    cyc(1, 2, 8'h22, 1, 0);
    #2 reset_n = 0;
    #1;
    m_reset();
    chk("midrst_ops", ops, 0);
    chk("midrst_op", op, 0);
    chk("midrst_ov", out_valid, 0);
    @(negedge clock) reset_n = 1;
    cyc(1, 1, 8'hA1, 1, 0);
    cyc(1, 1, 8'hB2, 1, 0);
    cyc(1, 2, 8'hC3, 1, 0);
    cyc(1, 2, 8'hD4, 1, 0);
    cyc(1, 0, 8'h06, 0, 0);
    chk("post_rst_ops", ops, 32'hC3D4A1B2);
    chk("post_rst_op", op, 6);
    cyc(0, 0, 8'h00, 1, 0);
`ifdef IN_PARITY_EN
    cyc(1, 1, 8'h12, 1, 1);
    chk("par_bad_err", err, 1);
    chk("par_bad_ops", ops[15:0], 16'hA1B2);
    cyc(1, 1, 8'h12, 1, 0);
    chk("par_good_err", err, 0);
    chk("par_good_msb", ops[15:0], 16'h12B2);
    cyc(1, 1, 8'h34, 1, 0);
    chk("par_good_lsb", ops[15:0], 16'h1234);
`endif
    for (int i = 0; i < 600; i++) begin
      logic bp;
`ifdef IN_PARITY_EN
      bp = $urandom_range(0, 7) == 0;
`else
      bp = 1'b0;
`endif
      cyc($urandom_range(0, 3) != 0, TAG_W'($urandom), CHUNK_W'($urandom), 1'($urandom), bp);
    end
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
